// File: rtl/csr_trap_ctrl.sv
// Machine-mode trap/mret sequencer: walks mepc/mcause/mstatus updates through a
// single-port CSR file and issues a one-cycle PC redirect at the end of each sequence.
module csr_trap_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic        trap_valid,
  input  logic [63:0] trap_epc,
  input  logic [3:0]  trap_cause,
  output logic        trap_ready,
  input  logic        mret_valid,
  output logic        mret_ready,
  input  logic        csr_req,
  input  logic [1:0]  pipe_waddr,
  input  logic [63:0] pipe_wdata,
  input  logic [1:0]  pipe_raddr,
  output logic        csr_gnt,
  output logic [1:0]  csr_raddr,
  input  logic [63:0] csr_rdata,
  output logic        csr_wen,
  output logic [1:0]  csr_waddr,
  output logic [63:0] csr_wdata,
  output logic        redirect_valid,
  output logic [63:0] redirect_pc,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE, T_EPC, T_CAUSE, T_STAT, T_JUMP, R_STAT, R_JUMP
  } state_t;

  localparam logic [1:0] MSTATUS = 2'd0;
  localparam logic [1:0] MTVEC   = 2'd1;
  localparam logic [1:0] MEPC    = 2'd2;
  localparam logic [1:0] MCAUSE  = 2'd3;

  state_t      state_q, state_d;
  logic [63:0] epc_q, epc_d;
  logic [3:0]  cause_q, cause_d;
  logic        idle_ok;

  // Trap entry: stash MIE into MPIE, disable interrupts, record M as previous mode.
  function automatic logic [63:0] mstatus_on_trap(input logic [63:0] s);
    logic [63:0] r;
    r        = s;
    r[7]     = s[3];
    r[3]     = 1'b0;
    r[12:11] = 2'b11;
    return r;
  endfunction

  function automatic logic [63:0] mstatus_on_mret(input logic [63:0] s);
    logic [63:0] r;
    r        = s;
    r[3]     = s[7];
    r[7]     = 1'b1;
    r[12:11] = 2'b11;
    return r;
  endfunction

  // Handshakes are combinational, so they must be masked while reset is held.
  assign idle_ok = (state_q == IDLE) && !reset;
  assign busy    = (state_q != IDLE);

  always_comb begin
    state_d        = state_q;
    epc_d          = epc_q;
    cause_d        = cause_q;
    trap_ready     = 1'b0;
    mret_ready     = 1'b0;
    csr_gnt        = 1'b0;
    csr_raddr      = 2'd0;
    csr_wen        = 1'b0;
    csr_waddr      = 2'd0;
    csr_wdata      = 64'd0;
    redirect_valid = 1'b0;
    redirect_pc    = 64'd0;
    case (state_q)
      IDLE: begin
        csr_raddr = pipe_raddr;
        csr_waddr = pipe_waddr;
        csr_wdata = pipe_wdata;
        if (idle_ok) begin
          if (trap_valid) begin
            trap_ready = 1'b1;
            epc_d      = trap_epc;
            cause_d    = trap_cause;
            state_d    = T_EPC;
          end else if (mret_valid) begin
            mret_ready = 1'b1;
            state_d    = R_STAT;
          end else if (csr_req) begin
            csr_gnt = 1'b1;
            csr_wen = 1'b1;
          end
        end
      end
      T_EPC: begin
        csr_wen   = 1'b1;
        csr_waddr = MEPC;
        csr_wdata = epc_q;
        state_d   = T_CAUSE;
      end
      T_CAUSE: begin
        csr_wen   = 1'b1;
        csr_waddr = MCAUSE;
        csr_wdata = {60'd0, cause_q};
        state_d   = T_STAT;
      end
      T_STAT: begin
        csr_raddr = MSTATUS;
        csr_wen   = 1'b1;
        csr_waddr = MSTATUS;
        csr_wdata = mstatus_on_trap(csr_rdata);
        state_d   = T_JUMP;
      end
      T_JUMP: begin
        csr_raddr      = MTVEC;
        redirect_valid = 1'b1;
        redirect_pc    = {csr_rdata[63:2], 2'b00};
        state_d        = IDLE;
      end
      R_STAT: begin
        csr_raddr = MSTATUS;
        csr_wen   = 1'b1;
        csr_waddr = MSTATUS;
        csr_wdata = mstatus_on_mret(csr_rdata);
        state_d   = R_JUMP;
      end
      R_JUMP: begin
        csr_raddr      = MEPC;
        redirect_valid = 1'b1;
        redirect_pc    = csr_rdata;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      epc_q   <= 64'd0;
      cause_q <= 4'd0;
    end else begin
      state_q <= state_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
    end
  end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Scoreboard bench for csr_trap_ctrl: a behavioural CSR file answers reads, and every
// CSR write / redirect the DUT emits is matched against a queue of timed expectations.
module tb_csr_trap_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        trap_valid, mret_valid, csr_req;
  logic [63:0] trap_epc, pipe_wdata;
  logic [3:0]  trap_cause;
  logic [1:0]  pipe_waddr, pipe_raddr;
  logic        trap_ready, mret_ready, csr_gnt, csr_wen, redirect_valid, busy;
  logic [1:0]  csr_raddr, csr_waddr;
  logic [63:0] csr_rdata, csr_wdata, redirect_pc;

  typedef struct {
    bit          is_redir;
    logic [1:0]  addr;
    logic [63:0] data;
    int          cyc;
  } ev_t;

  ev_t         exp_q[$];
  logic [63:0] csr_mem [4];
  logic [63:0] mdl [4];
  int          cyc = 0;
  int          n_run = 0;
  int          n_fail = 0;

  csr_trap_ctrl dut (
    .clock(clock), .reset(reset),
    .trap_valid(trap_valid), .trap_epc(trap_epc), .trap_cause(trap_cause), .trap_ready(trap_ready),
    .mret_valid(mret_valid), .mret_ready(mret_ready),
    .csr_req(csr_req), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata), .pipe_raddr(pipe_raddr),
    .csr_gnt(csr_gnt), .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
    .csr_wen(csr_wen), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  assign csr_rdata = csr_mem[csr_raddr];
  always @(posedge clock) if (csr_wen) csr_mem[csr_waddr] <= csr_wdata;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] trap_ms(input logic [63:0] s);
    logic [63:0] r;
    r = s; r[7] = s[3]; r[3] = 1'b0; r[12:11] = 2'b11;
    return r;
  endfunction

  function automatic logic [63:0] mret_ms(input logic [63:0] s);
    logic [63:0] r;
    r = s; r[3] = s[7]; r[7] = 1'b1; r[12:11] = 2'b11;
    return r;
  endfunction

  task automatic push_ev(input bit r, input logic [1:0] a, input logic [63:0] d, input int c);
    ev_t e;
    e.is_redir = r; e.addr = a; e.data = d; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic expect_trap(input logic [63:0] epc, input logic [3:0] cause, input int c0);
    logic [63:0] ms;
    ms = trap_ms(mdl[0]);
    push_ev(1'b0, 2'd2, epc, c0 + 1);
    push_ev(1'b0, 2'd3, {60'd0, cause}, c0 + 2);
    push_ev(1'b0, 2'd0, ms, c0 + 3);
    push_ev(1'b1, 2'd0, {mdl[1][63:2], 2'b00}, c0 + 4);
    mdl[2] = epc; mdl[3] = {60'd0, cause}; mdl[0] = ms;
  endtask

  task automatic expect_mret(input int c0);
    logic [63:0] ms;
    ms = mret_ms(mdl[0]);
    push_ev(1'b0, 2'd0, ms, c0 + 1);
    push_ev(1'b1, 2'd0, mdl[2], c0 + 2);
    mdl[0] = ms;
  endtask

  // Scoreboard monitor: every write and redirect must be the next expected event, on time.
  always @(negedge clock) begin
    ev_t e;
    if (csr_wen) begin
      if (exp_q.size() == 0) check_val("spurious_wr", 64'(csr_waddr) | 64'h100, 64'd0);
      else begin
        e = exp_q.pop_front();
        check_val("wr_kind", 64'(e.is_redir), 64'd0);
        check_val("wr_addr", 64'(csr_waddr), 64'(e.addr));
        check_val("wr_data", csr_wdata, e.data);
        check_val("wr_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
    if (redirect_valid) begin
      if (exp_q.size() == 0) check_val("spurious_redir", redirect_pc, 64'd0 - 1);
      else begin
        e = exp_q.pop_front();
        check_val("redir_kind", 64'(e.is_redir), 64'd1);
        check_val("redir_pc", redirect_pc, e.data);
        check_val("redir_cycle", 64'(cyc), 64'(e.cyc));
      end
    end else begin
      check_val("redir_pc_idle", redirect_pc, 64'd0);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pipe_wr(input logic [1:0] a, input logic [63:0] d);
    csr_req = 1'b1; pipe_waddr = a; pipe_wdata = d;
    push_ev(1'b0, a, d, cyc);
    mdl[a] = d;
    @(negedge clock);
    check_val("pipe_gnt", 64'(csr_gnt), 64'd1);
    step();
    csr_req = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(negedge clock);
    while (busy && n < 30) begin
      @(negedge clock);
      n++;
    end
    check_val(tag, 64'(busy), 64'd0);
    step();
  endtask

  initial begin
    int c0;
    reset = 1'b1; trap_valid = 1'b1; mret_valid = 1'b1; csr_req = 1'b1;
    trap_epc = 64'd0; trap_cause = 4'd0; pipe_waddr = 2'd0; pipe_wdata = 64'd0; pipe_raddr = 2'd0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_val("rst_trap_ready", 64'(trap_ready), 64'd0);
    check_val("rst_mret_ready", 64'(mret_ready), 64'd0);
    check_val("rst_gnt", 64'(csr_gnt), 64'd0);
    check_val("rst_wen", 64'(csr_wen), 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_redir", 64'(redirect_valid), 64'd0);
    step();
    trap_valid = 1'b0; mret_valid = 1'b0; csr_req = 1'b0;
    reset = 1'b0;
    step();

    pipe_wr(2'd0, 64'h0000_000A_0000_1808);
    pipe_wr(2'd1, 64'h0000_0000_8000_1003);
    pipe_raddr = 2'd2;
    @(negedge clock);
    check_val("idle_raddr", 64'(csr_raddr), 64'd2);
    step();

    // Reference trap with literal expectations.
    trap_valid = 1'b1; trap_epc = 64'h8000_0010; trap_cause = 4'd2; c0 = cyc;
    push_ev(1'b0, 2'd2, 64'h8000_0010, c0 + 1);
    push_ev(1'b0, 2'd3, 64'h2, c0 + 2);
    push_ev(1'b0, 2'd0, 64'h0000_000A_0000_1880, c0 + 3);
    push_ev(1'b1, 2'd0, 64'h8000_1000, c0 + 4);
    mdl[2] = 64'h8000_0010; mdl[3] = 64'h2; mdl[0] = 64'h0000_000A_0000_1880;
    @(negedge clock);
    check_val("t1_trap_ready", 64'(trap_ready), 64'd1);
    step();
    trap_valid = 1'b0;
    @(negedge clock);
    check_val("t1_busy", 64'(busy), 64'd1);
    wait_idle("t1_idle_timeout");

    // Reference mret.
    pipe_wr(2'd2, 64'h8000_0014);
    mret_valid = 1'b1; c0 = cyc;
    push_ev(1'b0, 2'd0, 64'h0000_000A_0000_1888, c0 + 1);
    push_ev(1'b1, 2'd0, 64'h8000_0014, c0 + 2);
    mdl[0] = 64'h0000_000A_0000_1888;
    @(negedge clock);
    check_val("m1_mret_ready", 64'(mret_ready), 64'd1);
    step();
    mret_valid = 1'b0;
    wait_idle("m1_idle_timeout");

    // Trap and mret together: trap wins, mret taken right after T_JUMP.
    trap_valid = 1'b1; mret_valid = 1'b1;
    trap_epc = 64'h1234_5678_9ABC_DEF4; trap_cause = 4'd5; c0 = cyc;
    expect_trap(trap_epc, trap_cause, c0);
    expect_mret(c0 + 5);
    @(negedge clock);
    check_val("tm_trap_ready", 64'(trap_ready), 64'd1);
    check_val("tm_mret_ready0", 64'(mret_ready), 64'd0);
    step();
    trap_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check_val("tm_mret_held", 64'(mret_ready), 64'd0);
      step();
    end
    @(negedge clock);
    check_val("tm_mret_ready1", 64'(mret_ready), 64'd1);
    step();
    mret_valid = 1'b0;
    wait_idle("tm_idle_timeout");

    // Pipeline write held off by a trap, granted once IDLE.
    trap_valid = 1'b1; trap_epc = 64'hFFFF_0000_0000_0100; trap_cause = 4'd7; c0 = cyc;
    expect_trap(trap_epc, trap_cause, c0);
    @(negedge clock);
    check_val("pw_trap_ready", 64'(trap_ready), 64'd1);
    step();
    trap_valid = 1'b0;
    csr_req = 1'b1; pipe_waddr = 2'd1; pipe_wdata = 64'h4000_0007;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check_val("pw_gnt_busy", 64'(csr_gnt), 64'd0);
      step();
    end
    push_ev(1'b0, 2'd1, 64'h4000_0007, cyc);
    mdl[1] = 64'h4000_0007;
    @(negedge clock);
    check_val("pw_gnt_idle", 64'(csr_gnt), 64'd1);
    step();
    csr_req = 1'b0;

    // Back-to-back traps with cause 15; second one redirects to masked mtvec.
    trap_valid = 1'b1; trap_epc = 64'h0000_0000_0000_2000; trap_cause = 4'd15; c0 = cyc;
    expect_trap(trap_epc, trap_cause, c0);
    expect_trap(trap_epc, trap_cause, c0 + 5);
    @(negedge clock);
    check_val("bb_ready0", 64'(trap_ready), 64'd1);
    step();
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check_val("bb_ready_busy", 64'(trap_ready), 64'd0);
      step();
    end
    @(negedge clock);
    check_val("bb_ready1", 64'(trap_ready), 64'd1);
    step();
    trap_valid = 1'b0;
    wait_idle("bb_idle_timeout");

    // Reset in T_CAUSE aborts the sequence after the mepc write.
    trap_valid = 1'b1; trap_epc = 64'h0000_0000_0000_3000; trap_cause = 4'd9; c0 = cyc;
    push_ev(1'b0, 2'd2, trap_epc, c0 + 1);
    mdl[2] = trap_epc;
    @(negedge clock);
    check_val("ra_trap_ready", 64'(trap_ready), 64'd1);
    step();
    trap_valid = 1'b0;
    step();
    reset = 1'b1;
    #1;
    check_val("ra_busy_now", 64'(busy), 64'd0);
    @(negedge clock);
    check_val("ra_wen", 64'(csr_wen), 64'd0);
    check_val("ra_redir", 64'(redirect_valid), 64'd0);
    step();
    reset = 1'b0;
    repeat (8) step();
    check_val("ra_busy_after", 64'(busy), 64'd0);

    check_val("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
